// File: rtl/amba_pkg.sv
// amba_pkg: shared AHB-Lite definitions for the SRAM slave and its helpers.
//   AWIDTH        - bus address width
//   htrans_t      - transfer type encodings
//   HSIZE_*       - transfer size encodings
//   sram_state_t  - SRAM slave state machine states
package amba_pkg;

    localparam int AWIDTH = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } sram_state_t;

endpackage

// File: rtl/ahb_byte_en.sv
// ahb_byte_en: combinational byte-lane enables for an AHB transfer.
//   size  in  3       transfer size (sizes wider than the bus count as full width)
//   addr  in  LW      byte address bits within one bus word
//   be    out LANES   lane enables, lane i covers data[8i+:8] (little-endian)
// A misaligned address is implicitly aligned down to the transfer size.
module ahb_byte_en #(
    parameter  int DATA_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int LW     = $clog2(LANES)
) (
    input  logic [2:0]       size,
    input  logic [LW-1:0]    addr,
    output logic [LANES-1:0] be
);

    logic [2:0] size_c;

    assign size_c = (size > 3'(LW)) ? 3'(LW) : size;

    // A lane belongs to the transfer when it lies in the same size-aligned
    // block as the address: compare both after dropping the low size bits.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign be[gi] = ((LW'(gi) >> size_c) == (addr >> size_c));
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: parametrised AHB-Lite SRAM slave with per-type wait states.
//   clk, rst_n        clock, asynchronous active-low reset
//   hsel, haddr, hsize, hwrite, htrans, hready   address phase inputs
//   hwdata            write data (data phase)
//   hreadyout, hresp, hrdata   slave response
// Optional build macro AHB_SRAM_ERR_EN: illegal size or misaligned transfers
// get a two-cycle ERROR response; otherwise they are clamped/aligned and OKAY.
module ahb_sram_slave
    import amba_pkg::*;
#(
    parameter int MEM_BYTE = 4096,
    parameter int DATA_W   = 32,
    parameter int WAIT_RD  = 2,
    parameter int WAIT_WR  = 0,
    parameter int WAIT_SEQ = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [AWIDTH-1:0] haddr,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int LANES = DATA_W / 8;
    localparam int LW    = $clog2(LANES);
    localparam int AW    = $clog2(MEM_BYTE);
    localparam int DEPTH = MEM_BYTE / LANES;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("ahb_sram_slave: DATA_W must be 32 or 64");
        end
        if (MEM_BYTE < LANES || (MEM_BYTE & (MEM_BYTE - 1)) != 0) begin : g_bad_mem
            $error("ahb_sram_slave: MEM_BYTE must be a power of two >= DATA_W/8");
        end
        if (WAIT_RD < 0 || WAIT_RD > 15 || WAIT_WR < 0 || WAIT_WR > 15 ||
            WAIT_SEQ < 0 || WAIT_SEQ > 15) begin : g_bad_wait
            $error("ahb_sram_slave: wait counts must be 0..15");
        end
    endgenerate

    sram_state_t       state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [AW-1:0]     addr_reg;
    logic [2:0]        size_reg;
    logic              write_reg;
    logic              load;
    logic              accept;
    logic              illegal;
    logic [3:0]        n_wait;
    htrans_t           trans;
    logic [LANES-1:0]  be;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              addr_hi_unused;

    // Address bits above the memory size simply alias.
    assign addr_hi_unused = ^haddr[AWIDTH-1:AW];

    assign trans  = htrans_t'(htrans);
    assign accept = hsel & hready & htrans[1];
    assign n_wait = (trans == HTRANS_SEQ) ? 4'(WAIT_SEQ) :
                    (hwrite ? 4'(WAIT_WR) : 4'(WAIT_RD));

`ifdef AHB_SRAM_ERR_EN
    logic [LW-1:0] amask;
    assign amask   = ~({LW{1'b1}} << hsize);
    assign illegal = (hsize > 3'(LW)) || ((haddr[LW-1:0] & amask) != '0);
    assign hresp   = (state_reg == ERR1) || (state_reg == ERR2);
`else
    assign illegal = 1'b0;
    assign hresp   = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        hreadyout  = 1'b1;
        case (state_reg)
            WAIT: begin
                hreadyout = 1'b0;
                if (cnt_reg == 4'd0) begin
                    state_next = DATA;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ERR1: begin
                hreadyout  = 1'b0;
                state_next = ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all drive hreadyout=1, so the current
                // address phase is sampled here (back-to-back transfers).
                state_next = IDLE;
                cnt_next   = 4'd0;
                if (accept) begin
                    load = 1'b1;
                    if (illegal) begin
                        state_next = ERR1;
                    end else if (n_wait != 4'd0) begin
                        state_next = WAIT;
                        cnt_next   = n_wait - 4'd1;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            size_reg  <= 3'd0;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (load) begin
                addr_reg  <= haddr[AW-1:0];
                size_reg  <= hsize;
                write_reg <= hwrite;
            end
        end
    end

    ahb_byte_en #(
        .DATA_W (DATA_W)
    ) u_byte_en (
        .size (size_reg),
        .addr (addr_reg[LW-1:0]),
        .be   (be)
    );

    assign idx = IW'(addr_reg >> LW);

    // Memory is deliberately not reset. Writes commit on the edge that ends
    // DATA, so a read in the following data phase already sees the new word.
    always_ff @(posedge clk) begin
        if (state_reg == DATA && write_reg) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hrdata = (state_reg == DATA && !write_reg) ? mem[idx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: self-checking bench for ahb_sram_slave (32-bit bus).
// A pipelined master drives queued transfers; a byte-array reference model
// produces the expected response at acceptance and a scoreboard compares it
// when the data phase completes. Build with AHB_SRAM_ERR_EN to cover ERROR.
module tb_ahb_sram_slave;
    import amba_pkg::*;

    localparam int MEM_BYTE = 4096;
    localparam int DATA_W   = 32;
    localparam int WAIT_RD  = 2;
    localparam int WAIT_WR  = 0;
    localparam int WAIT_SEQ = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hsel = 1'b0;
    logic [AWIDTH-1:0] haddr = '0;
    logic [2:0]        hsize = 3'd0;
    logic              hwrite = 1'b0;
    logic [1:0]        htrans = 2'b00;
    logic [DATA_W-1:0] hwdata = '0;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    assign hready = hreadyout;

    always #5 clk = ~clk;

    ahb_sram_slave #(
        .MEM_BYTE (MEM_BYTE),
        .DATA_W   (DATA_W),
        .WAIT_RD  (WAIT_RD),
        .WAIT_WR  (WAIT_WR),
        .WAIT_SEQ (WAIT_SEQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    typedef struct {
        string       tag;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        seq;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        string       tag;
        logic        rd;
        logic [31:0] data;
        int          waits;
        logic        resp;
    } exp_t;

    xfer_t      pend[$];
    exp_t       sb[$];
    logic [7:0] ref_mem [MEM_BYTE];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic seq, input logic [31:0] wdata);
        xfer_t x;
        x.tag = tag; x.write = wr; x.addr = addr; x.size = size; x.seq = seq; x.wdata = wdata;
        pend.push_back(x);
    endtask

    // Reference model: byte-addressed memory, responses derived from the
    // wait-state parameters and the legality rules of the build.
    function automatic exp_t model(input xfer_t x);
        exp_t e;
        int   sz;
        int   n;
        int   base;
        logic bad;
        e.tag = x.tag; e.rd = !x.write; e.data = '0; e.resp = 1'b0;
        bad = 1'b0;
`ifdef AHB_SRAM_ERR_EN
        bad = (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0);
`endif
        if (bad) begin
            e.rd = 1'b1; e.data = '0; e.resp = 1'b1; e.waits = 1;
            return e;
        end
        sz   = (x.size > 3'd2) ? 2 : int'(x.size);
        n    = 1 << sz;
        base = int'(x.addr % MEM_BYTE);
        base = base - (base % n);
        e.waits = x.seq ? WAIT_SEQ : (x.write ? WAIT_WR : WAIT_RD);
        if (x.write) begin
            for (int k = 0; k < n; k++)
                ref_mem[base + k] = x.wdata[8*((base + k) % 4) +: 8];
        end else begin
            int w;
            w = base - (base % 4);
            e.data = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
        end
        return e;
    endfunction

    // Pipelined master: address phase of the next transfer overlaps the
    // data phase of the previous one; hready follows hreadyout.
    task automatic run();
        xfer_t       x;
        exp_t        cur;
        bit          busy = 1'b0;
        bit          resp_bad = 1'b0;
        int          waits = 0;
        logic [31:0] dwdata = '0;
        while (pend.size() > 0 || busy) begin
            if (pend.size() > 0) begin
                x      = pend[0];
                hsel   = 1'b1;
                htrans = x.seq ? 2'b11 : 2'b10;
                haddr  = x.addr;
                hsize  = x.size;
                hwrite = x.write;
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
            end
            @(negedge clk);
            if (busy && hresp !== sb[0].resp) resp_bad = 1'b1;
            if (hreadyout === 1'b1) begin
                if (busy) begin
                    cur = sb.pop_front();
                    check({cur.tag, "_waits"}, 64'(waits), 64'(cur.waits));
                    check({cur.tag, "_resp"}, 64'(resp_bad), 64'd0);
                    if (cur.rd) check({cur.tag, "_rdata"}, 64'(hrdata), 64'(cur.data));
                    $display("txn %-12s waits=%0d hresp=%0b hrdata=%08h", cur.tag, waits, hresp, hrdata);
                end
                busy = 1'b0;
                if (pend.size() > 0) begin
                    x = pend.pop_front();
                    sb.push_back(model(x));
                    dwdata = x.wdata;
                    busy = 1'b1;
                end
                waits = 0;
                resp_bad = 1'b0;
            end else begin
                waits++;
                if (waits > 50) begin
                    check("timeout_hreadyout", 64'(hreadyout), 64'd1);
                    pend.delete();
                    sb.delete();
                    hsel = 1'b0; htrans = 2'b00;
                    return;
                end
            end
            @(posedge clk);
            #1;
            hwdata = dwdata;
        end
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_hreadyout", 64'(hreadyout), 64'd1);
        check("rst_hresp", 64'(hresp), 64'd0);
        check("rst_hrdata", 64'(hrdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word write then NONSEQ read with WAIT_RD waits
        add("wr10", 1'b1, 32'h10, 3'd2, 1'b0, 32'hDEADBEEF);
        add("rd10", 1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
        run();

        // Byte write into lane 3, word read back
        add("wrb13", 1'b1, 32'h13, 3'd0, 1'b0, 32'hAA000000);
        add("rd10b", 1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
        run();

        // INCR4 write burst then INCR4 read burst
        add("bw40", 1'b1, 32'h40, 3'd2, 1'b0, 32'h11111111);
        add("bw44", 1'b1, 32'h44, 3'd2, 1'b1, 32'h22222222);
        add("bw48", 1'b1, 32'h48, 3'd2, 1'b1, 32'h33333333);
        add("bw4c", 1'b1, 32'h4C, 3'd2, 1'b1, 32'h44444444);
        run();
        add("br40", 1'b0, 32'h40, 3'd2, 1'b0, 32'h0);
        add("br44", 1'b0, 32'h44, 3'd2, 1'b1, 32'h0);
        add("br48", 1'b0, 32'h48, 3'd2, 1'b1, 32'h0);
        add("br4c", 1'b0, 32'h4C, 3'd2, 1'b1, 32'h0);
        run();

        // Back-to-back write then read of the same word
        add("wr20", 1'b1, 32'h20, 3'd2, 1'b0, 32'h12345678);
        add("rd20", 1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
        run();

        // Misaligned halfword: ERROR with the macro, aligned down without it
        add("wrh21", 1'b1, 32'h21, 3'd1, 1'b0, 32'hCAFECAFE);
        run();
        add("rd20h", 1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
        run();

        // Oversized transfer (doubleword on a 32-bit bus)
        add("wrd24", 1'b1, 32'h24, 3'd3, 1'b0, 32'h5A5A0F0F);
        run();
        add("rd24", 1'b0, 32'h24, 3'd2, 1'b0, 32'h0);
        run();

        // Address aliasing beyond MEM_BYTE
        add("wrwrap", 1'b1, 32'h1030, 3'd2, 1'b0, 32'hCAFEF00D);
        add("rdwrap", 1'b0, 32'h30, 3'd2, 1'b0, 32'h0);
        run();

        // Reset asserted during the WAIT state of a read
        @(negedge clk);
        @(posedge clk);
        #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b0;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00;
        check("wait_hreadyout", 64'(hreadyout), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_hreadyout", 64'(hreadyout), 64'd1);
        check("midrst_hresp", 64'(hresp), 64'd0);
        check("midrst_hrdata", 64'(hrdata), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add("rd10post", 1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
        run();

        // Random word traffic
        for (int i = 0; i < 6; i++) begin
            a = 32'h200 + 32'(4 * $urandom_range(0, 15));
            add("rndwr", 1'b1, a, 3'd2, 1'b0, $urandom);
            add("rndrd", 1'b0, a, 3'd2, 1'b0, 32'h0);
            run();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite SRAM slave and successor to the fixed 32-bit, fixed-wait memory slave. It sits behind the AHB decoder/multiplexer like any other slave. Compared with the previous slave it adds a configurable data width, separate wait-state counts for NONSEQ reads, writes and SEQ beats, a registered state machine, and an optional two-cycle ERROR response for illegal transfers.

## Interface
- MEM_BYTE, 4096: memory size in bytes; power of two, at least DATA_W/8; elaboration error otherwise.
- DATA_W, 32: data bus width; 32 or 64; elaboration error otherwise.
- WAIT_RD, 2: wait states inserted on a NONSEQ read, 0..15.
- WAIT_WR, 0: wait states inserted on a NONSEQ write, 0..15.
- WAIT_SEQ, 0: wait states inserted on any SEQ beat, 0..15.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  AWIDTH  byte address; only the low $clog2(MEM_BYTE) bits are used.
- hsize  in  3  transfer size.
- hwrite  in  1  1 = write.
- htrans  in  2  IDLE / BUSY / NONSEQ / SEQ.
- hwdata  in  DATA_W  write data, valid in the data phase.
- hready  in  1  bus ready.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_W  read data.

## Operation
- Address phase accepted when hsel & hready & htrans[1]. On acceptance the slave registers address, size, write and trans (SEQ or not).
- hsel & hready with IDLE or BUSY, or with hsel low: no transfer. The next cycle is a zero-wait OKAY (hreadyout=1).
- Wait count N for an accepted transfer:
  - SEQ beat: N = WAIT_SEQ.
  - NONSEQ read: N = WAIT_RD.
  - NONSEQ write: N = WAIT_WR.
- State machine:
  - IDLE: hreadyout=1.
  - An accepted transfer with N>0 goes to WAIT. An accepted transfer with N=0 goes to DATA.
  - WAIT: hreadyout=0. A down-counter is loaded with N-1; when the counter reaches 0, go to DATA.
  - DATA: hreadyout=1; the transfer completes this cycle. Next state is re-evaluated from the current address phase (back-to-back transfers allowed), else IDLE.
- Byte enables: derived from the registered hsize and address low bits. Lanes are little-endian; lane i covers hwdata[8i+:8].
- Write: enabled lanes are committed to the memory word at the clock edge ending DATA.
- Read: hrdata = memory word at the registered address while in DATA; 0 in all other states.
  - A read whose data phase directly follows a write to the same word returns the new data.
- The memory array is not reset; its contents are undefined after power-up.
- Reset values: hreadyout=1, hresp=0, hrdata=0, state IDLE, counter 0.
- Reset asserted mid-transfer: the transfer is aborted, no write occurs, and all outputs take their reset values immediately.

## Timing
- Read latency: the address-phase edge plus WAIT_RD cycles with hreadyout=0. Data is returned in the following cycle with hreadyout=1.
- Write: same sequence with WAIT_WR. Data is captured in the cycle hreadyout=1.
- While hreadyout=0, changes on the address-phase inputs are ignored. The hready input gates all acceptance.
- Address wrap: an address at or beyond MEM_BYTE aliases modulo MEM_BYTE.

## Configuration
- AHB_SRAM_ERR_EN defined: a transfer is illegal if either
  - hsize > log2(DATA_W/8), or
  - the address is not aligned to hsize.
- Illegal transfer with AHB_SRAM_ERR_EN: two-cycle ERROR.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - No write is performed and hrdata=0. Wait states are skipped.
- Macro undefined: hresp is tied to 0. An illegal size is treated as the full bus width. A misaligned address is aligned down to the transfer size; the transfer completes as OKAY.

## Structure
- amba_pkg holds:
  - AWIDTH.
  - The htrans encodings as enum htrans_t.
  - The hsize encodings.
  - State enum sram_state_t {IDLE, WAIT, DATA, ERR1, ERR2}.
- Sub-module ahb_byte_en: combinational function (hsize, addr low bits, DATA_W) -> byte-enable vector. It is reused by other slaves.

## Test plan
- WAIT_RD=2 NONSEQ read of 0x10 after a word write of 0xDEADBEEF: exactly 2 cycles of hreadyout=0, then hrdata=0xDEADBEEF with hresp=0.
- Byte write of 0xAA to address 0x13, then word read of 0x10: result 0xAAADBEEF; other lanes unchanged.
- INCR4 burst with WAIT_RD=3 and WAIT_SEQ=0: first beat takes 3 waits, then 3 consecutive zero-wait beats returning the 4 stored words.
- Write to 0x20 immediately followed by a read of 0x20 (back-to-back, WAIT_WR=0): the read returns the newly written value.
- With AHB_SRAM_ERR_EN, halfword write to 0x21: ERR1 then ERR2 (hresp=1 both cycles), and memory at 0x20 is unchanged. Without the macro, the same write updates bytes 0x20–0x21 and completes OKAY.
- rst_n pulsed low during the WAIT state of a read: hreadyout=1, hresp=0 and hrdata=0 immediately. After release, the next transfer behaves normally.
